// File: rtl/updown_counter_lim_if.sv
// updown_counter_lim_if: control, limit and status bundle for the limited up/down counter.
interface updown_counter_lim_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              en;
    logic              load;
    logic [WIDTH-1:0]  data_in;
    logic              up;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  lim_lo;
    logic [WIDTH-1:0]  lim_hi;
    logic [WIDTH-1:0]  count;
    logic              at_lo;
    logic              at_hi;
    logic              ovf;
    logic              unf;
    logic              cfg_err;
    modport master (
        output en, load, data_in, up, step, lim_lo, lim_hi,
        input  count, at_lo, at_hi, ovf, unf, cfg_err
    );
    modport slave (
        input  en, load, data_in, up, step, lim_lo, lim_hi,
        output count, at_lo, at_hi, ovf, unf, cfg_err
    );
endinterface

// File: rtl/updown_counter_lim.sv
// updown_counter_lim: up/down counter with programmable limits, variable step, load and saturate/wrap.
module updown_counter_lim #(
    parameter int               WIDTH   = 8,
    parameter int               STEP_W  = 4,
    parameter bit               WRAP    = 1'b0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic                 clk,
    input logic                 rst,
    updown_counter_lim_if.slave bus
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic [WIDTH:0]   step_x, s;
    logic [WIDTH-1:0] lo, hi, load_v;
    logic             cfg_err;
    assign lo      = bus.lim_lo;
    assign hi      = bus.lim_hi;
    assign cfg_err = lo > hi;
    assign step_x  = {{(WIDTH + 1 - STEP_W){1'b0}}, bus.step};
    // Bit WIDTH of s doubles as the borrow flag on down-counts.
    assign s       = bus.up ? {1'b0, count_q} + step_x : {1'b0, count_q} - step_x;
    assign load_v  = bus.data_in < lo ? lo : bus.data_in > hi ? hi : bus.data_in;
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (cfg_err) begin
            count_d = count_q;
        end else if (bus.load) begin
            count_d = load_v;
        end else if (bus.en) begin
            if (count_q < lo) begin
                count_d = lo;
            end else if (count_q > hi) begin
                count_d = hi;
            end else if (bus.step != '0) begin
                if (bus.up) begin
                    ovf_d   = s > {1'b0, hi};
                    count_d = ovf_d ? (WRAP ? lo : hi) : s[WIDTH-1:0];
                end else begin
                    unf_d   = s[WIDTH] || s < {1'b0, lo};
                    count_d = unf_d ? (WRAP ? hi : lo) : s[WIDTH-1:0];
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_VAL;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
    assign bus.count   = count_q;
    assign bus.at_lo   = count_q == lo;
    assign bus.at_hi   = count_q == hi;
    assign bus.ovf     = ovf_q;
    assign bus.unf     = unf_q;
    assign bus.cfg_err = cfg_err;
endmodule

// File: tb/tb_updown_counter_lim.sv
// tb_updown_counter_lim: saturate and wrap instances driven in lockstep, checked against an integer model.
module tb_updown_counter_lim;
    localparam int RST = 5;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   m_cnt[2];
    int   m_ovf[2];
    int   m_unf[2];
    updown_counter_lim_if #(.WIDTH(8), .STEP_W(4)) i0 ();
    updown_counter_lim_if #(.WIDTH(8), .STEP_W(4)) i1 ();
    updown_counter_lim #(.WIDTH(8), .STEP_W(4), .WRAP(1'b0), .RST_VAL(8'd5)) dut0 (
        .clk(clk), .rst(rst), .bus(i0.slave));
    updown_counter_lim #(.WIDTH(8), .STEP_W(4), .WRAP(1'b1), .RST_VAL(8'd5)) dut1 (
        .clk(clk), .rst(rst), .bus(i1.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic cyc(input int r, input int e, input int l, input int d,
                       input int u, input int s, input int lo, input int hi);
        @(negedge clk);
        rst = r[0];
        i0.en = e[0]; i0.load = l[0]; i0.data_in = d[7:0]; i0.up = u[0];
        i0.step = s[3:0]; i0.lim_lo = lo[7:0]; i0.lim_hi = hi[7:0];
        i1.en = e[0]; i1.load = l[0]; i1.data_in = d[7:0]; i1.up = u[0];
        i1.step = s[3:0]; i1.lim_lo = lo[7:0]; i1.lim_hi = hi[7:0];
        for (int w = 0; w < 2; w++) begin
            int c, n, o, un;
            c = m_cnt[w]; n = c; o = 0; un = 0;
            if (r != 0) n = RST;
            else if (lo > hi) n = c;
            else if (l != 0) n = d < lo ? lo : (d > hi ? hi : d);
            else if (e != 0) begin
                if (c < lo) n = lo;
                else if (c > hi) n = hi;
                else if (s != 0 && u != 0) begin
                    if (c + s > hi) begin n = (w == 1) ? lo : hi; o = 1; end
                    else n = c + s;
                end else if (s != 0) begin
                    if (c - s < lo) begin n = (w == 1) ? hi : lo; un = 1; end
                    else n = c - s;
                end
            end
            m_cnt[w] = n; m_ovf[w] = o; m_unf[w] = un;
        end
        @(posedge clk);
        #1;
        chk("count0", int'(i0.count), m_cnt[0]);
        chk("ovf0", int'(i0.ovf), m_ovf[0]);
        chk("unf0", int'(i0.unf), m_unf[0]);
        chk("at_lo0", int'(i0.at_lo), int'(m_cnt[0] == lo));
        chk("at_hi0", int'(i0.at_hi), int'(m_cnt[0] == hi));
        chk("cfg_err0", int'(i0.cfg_err), int'(lo > hi));
        chk("count1", int'(i1.count), m_cnt[1]);
        chk("ovf1", int'(i1.ovf), m_ovf[1]);
        chk("unf1", int'(i1.unf), m_unf[1]);
    endtask
    initial begin
        m_cnt = '{0, 0}; m_ovf = '{0, 0}; m_unf = '{0, 0};
        // reset dominates load/en, then a mid-count reset restarts from RST
        cyc(1, 1, 1, 99, 1, 3, 0, 255);
        cyc(0, 1, 0, 0, 1, 3, 0, 255);
        cyc(0, 1, 0, 0, 1, 3, 0, 255);
        cyc(1, 1, 0, 0, 1, 3, 0, 255);
        cyc(0, 1, 0, 0, 1, 1, 0, 255);
        // saturate / wrap on up-count, repeated exceed at the limit
        cyc(0, 1, 1, 18, 1, 3, 10, 20);
        cyc(0, 1, 0, 0, 1, 3, 10, 20);
        cyc(0, 1, 0, 0, 1, 3, 10, 20);
        cyc(0, 0, 0, 0, 1, 3, 10, 20);
        // down-count below lo, and borrow past zero
        cyc(0, 0, 1, 12, 0, 5, 10, 20);
        cyc(0, 1, 0, 0, 0, 5, 10, 20);
        cyc(0, 0, 1, 2, 0, 5, 0, 20);
        cyc(0, 1, 0, 0, 0, 5, 0, 20);
        cyc(0, 1, 0, 0, 0, 0, 0, 20);
        // load clamping
        cyc(0, 1, 1, 250, 1, 1, 0, 200);
        cyc(0, 1, 1, 5, 1, 1, 8, 200);
        // run-time limit change, then inverted limits freeze the count
        cyc(0, 0, 1, 100, 1, 1, 0, 255);
        cyc(0, 1, 0, 0, 1, 1, 0, 50);
        cyc(0, 1, 1, 7, 1, 1, 60, 50);
        cyc(0, 1, 0, 0, 0, 9, 60, 50);
        // full-range up-count must not wrap modulo 2^WIDTH
        cyc(0, 0, 1, 250, 1, 15, 0, 255);
        cyc(0, 1, 0, 0, 1, 15, 0, 255);
        // pinned range
        cyc(0, 0, 1, 40, 1, 2, 40, 40);
        cyc(0, 1, 0, 0, 1, 2, 40, 40);
        cyc(0, 1, 0, 0, 0, 2, 40, 40);
        begin
            int lo = 30, hi = 90;
            for (int k = 0; k < 3000; k++) begin
                int a, b, p;
                if ($urandom_range(0, 9) < 2) begin
                    a = $urandom_range(0, 255); b = $urandom_range(0, 255);
                    lo = a < b ? a : b; hi = a < b ? b : a;
                    p = $urandom_range(0, 19);
                    if (p == 0) begin lo = hi; end
                    else if (p == 1 && lo != hi) begin a = lo; lo = hi; hi = a; end
                end
                cyc(int'($urandom_range(0, 49) == 0), int'($urandom_range(0, 9) < 8),
                    int'($urandom_range(0, 9) == 0), $urandom_range(0, 255),
                    $urandom_range(0, 1), $urandom_range(0, 15), lo, hi);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
